// File: rtl/scan_dec_pkg.sv
// Shared types and constants for the scan decoder.
package scan_dec_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Values of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell timer: counts 0..dwell while running and pulses step on the last count.
// The dwell limit is sampled only when the count is at 0, so a change made
// part-way through a step applies from the following step.
module scan_dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] count_q, count_d;
  logic [DWELL_W-1:0] limit_q, limit_d;
  logic [DWELL_W-1:0] limit;

  // Next count, latched limit and the step pulse.
  always_comb begin
    limit   = (count_q == '0) ? dwell : limit_q;
    step    = run && (count_q == limit);
    count_d = count_q;
    limit_d = limit_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == '0) begin
        limit_d = dwell;
      end
      count_d = step ? '0 : count_q + DWELL_W'(1);
    end
  end

  // Counter and latched limit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// One-hot decoder with a direct-select mode and a timed scanning mode.
// All outputs are registered; onehot/valid are computed from next-state values
// so they always agree with the idx and state shown in the same cycle.
module scan_decoder
  import scan_dec_pkg::*;
#(
  parameter  int unsigned SEL_W   = 4,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned OUT_N   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   onehot,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_N-1:0]   onehot_q, onehot_d;
  logic               valid_q, wrap_q, wrap_d;
  logic               run, step;

  // Timer only runs while staying in SCAN without a load; anything else
  // (mode change, entry from IDLE, load, disable) restarts the step.
  assign run = en && (mode == MODE_SCAN) && (state_q == SCAN) && !load;

  scan_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .run   (run),
    .dwell (dwell),
    .step  (step)
  );

  // Next state, next index and wrap detection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_d = DIRECT;
      if (load) begin
        idx_d = sel_in;
      end
    end else begin
      state_d = SCAN;
      if (load) begin
        idx_d = sel_in;
      end else if (run && step) begin
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = &idx_q;
      end
    end
    onehot_d = (state_d != IDLE) ? (OUT_N'(1) << idx_d) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      valid_q  <= (state_d != IDLE);
      wrap_q   <= wrap_d;
    end
  end

  assign onehot = onehot_q;
  assign idx    = idx_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;

endmodule
